// File: rtl/alu_ctrl_muldiv.sv
// Execute-stage ALU control decode plus an iterative multiply/divide sequencer
// owning the HI/LO registers (shift-add multiply, restoring divide).
module alu_ctrl_muldiv #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned ALUOP_W = 3
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               valid_i,
  input  logic [5:0]         funct_i,
  input  logic [ALUOP_W-1:0] ALUOp_i,
  input  logic [WIDTH-1:0]   src1_i,
  input  logic [WIDTH-1:0]   src2_i,
  output logic [3:0]         ALUCtrl_o,
  output logic               stall_o,
  output logic               busy_o,
  output logic [WIDTH-1:0]   hi_o,
  output logic [WIDTH-1:0]   lo_o
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StFix} state_e;

  state_e             r_state, w_state_d;
  logic [CntW-1:0]    r_count;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_opnd;
  logic [WIDTH-1:0]   r_src1;
  logic               r_is_div;
  logic               r_neg_res;
  logic               r_neg_rem;
  logic [WIDTH-1:0]   r_hi, r_lo;

  logic               w_rtype, w_start, w_mtx, w_signed;
  logic [WIDTH-1:0]   w_abs1, w_abs2;
  logic [WIDTH:0]     w_mul_sum, w_rem_sh, w_rem_diff;
  logic               w_qbit;
  logic [2*WIDTH-1:0] w_mul_next, w_div_next, w_prod;
  logic [WIDTH-1:0]   w_quot, w_rem;

  // ---------------------------------------------------------------- decode
  always_comb begin
    ALUCtrl_o = 4'b1111;
    case (ALUOp_i)
      ALUOP_W'(2): begin
        case (funct_i)
          6'd32:   ALUCtrl_o = 4'b0010;
          6'd34:   ALUCtrl_o = 4'b0110;
          6'd36:   ALUCtrl_o = 4'b0000;
          6'd37:   ALUCtrl_o = 4'b0001;
          6'd42:   ALUCtrl_o = 4'b0111;
          6'd0:    ALUCtrl_o = 4'b0011;
          6'd6:    ALUCtrl_o = 4'b0100;
          6'd16:   ALUCtrl_o = 4'b1100;
          6'd18:   ALUCtrl_o = 4'b1101;
          default: ALUCtrl_o = 4'b1111;
        endcase
      end
      ALUOP_W'(4): ALUCtrl_o = 4'b0010;
      ALUOP_W'(1): ALUCtrl_o = 4'b0110;
      ALUOP_W'(5): ALUCtrl_o = 4'b0111;
      ALUOP_W'(3): ALUCtrl_o = 4'b1001;
      ALUOP_W'(0): ALUCtrl_o = 4'b1010;
      ALUOP_W'(7): ALUCtrl_o = 4'b1011;
      default:     ALUCtrl_o = 4'b1111;
    endcase
  end

  // ------------------------------------------------------------- sequencer
  assign w_rtype  = (ALUOp_i == ALUOP_W'(2));
  // Gated by reset so stall_o stays low while reset is held.
  assign w_start  = rst_i & valid_i & w_rtype & (funct_i[5:2] == 4'b0110) & (r_state == StIdle);
  assign w_mtx    = valid_i & w_rtype & ((funct_i == 6'd17) | (funct_i == 6'd19)) &
                    (r_state == StIdle);
  assign w_signed = ~funct_i[0];
  assign w_abs1   = (w_signed & src1_i[WIDTH-1]) ? -src1_i : src1_i;
  assign w_abs2   = (w_signed & src2_i[WIDTH-1]) ? -src2_i : src2_i;

  // Multiply: add multiplicand into the upper half when the low bit is set, then shift right.
  assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
  assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

  // Divide: upper half is the partial remainder, lower half shifts dividend out / quotient in.
  assign w_rem_sh   = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
  assign w_rem_diff = w_rem_sh - {1'b0, r_opnd};
  assign w_qbit     = ~w_rem_diff[WIDTH];
  assign w_div_next = {(w_qbit ? w_rem_diff[WIDTH-1:0] : w_rem_sh[WIDTH-1:0]),
                       r_acc[WIDTH-2:0], w_qbit};

  assign w_prod = r_neg_res ? -r_acc : r_acc;
  assign w_quot = r_neg_res ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
  assign w_rem  = r_neg_rem ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:       if (w_start) w_state_d = funct_i[1] ? StDiv : StMul;
      StMul, StDiv: if (r_count == CntLast) w_state_d = StFix;
      StFix:        w_state_d = StIdle;
      default:      w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state   <= StIdle;
      r_count   <= '0;
      r_acc     <= '0;
      r_opnd    <= '0;
      r_src1    <= '0;
      r_is_div  <= 1'b0;
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
    end else begin
      r_state <= w_state_d;
      if (w_start) begin
        r_count   <= '0;
        r_acc     <= {{WIDTH{1'b0}}, w_abs1};
        r_opnd    <= w_abs2;
        r_src1    <= src1_i;
        r_is_div  <= funct_i[1];
        r_neg_res <= w_signed & (src1_i[WIDTH-1] ^ src2_i[WIDTH-1]);
        r_neg_rem <= w_signed & src1_i[WIDTH-1];
      end else if (r_state == StMul) begin
        r_acc   <= w_mul_next;
        r_count <= r_count + CntW'(1);
      end else if (r_state == StDiv) begin
        r_acc   <= w_div_next;
        r_count <= r_count + CntW'(1);
      end
      if (w_mtx) begin
        if (funct_i[1]) r_lo <= src1_i;
        else            r_hi <= src1_i;
      end
      if (r_state == StFix) begin
        if (!r_is_div) begin
          r_hi <= w_prod[2*WIDTH-1:WIDTH];
          r_lo <= w_prod[WIDTH-1:0];
        end else if (r_opnd == '0) begin
          r_hi <= r_src1;
          r_lo <= '1;
        end else begin
          r_hi <= w_rem;
          r_lo <= w_quot;
        end
      end
    end
  end

  assign stall_o = w_start | (r_state == StMul) | (r_state == StDiv);
  assign busy_o  = (r_state != StIdle);
  assign hi_o    = r_hi;
  assign lo_o    = r_lo;

endmodule

// File: tb/tb_alu_ctrl_muldiv.sv
// Randomised and directed bench for alu_ctrl_muldiv against an arithmetic reference model.
module tb_alu_ctrl_muldiv;

  localparam int unsigned W = 32;

  logic         clk_i   = 1'b0;
  logic         rst_i   = 1'b0;
  logic         valid_i = 1'b0;
  logic [5:0]   funct_i = '0;
  logic [2:0]   ALUOp_i = '0;
  logic [W-1:0] src1_i  = '0;
  logic [W-1:0] src2_i  = '0;
  logic [3:0]   ALUCtrl_o;
  logic         stall_o;
  logic         busy_o;
  logic [W-1:0] hi_o;
  logic [W-1:0] lo_o;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  alu_ctrl_muldiv #(.WIDTH(W), .ALUOP_W(3)) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .valid_i  (valid_i),
    .funct_i  (funct_i),
    .ALUOp_i  (ALUOp_i),
    .src1_i   (src1_i),
    .src2_i   (src2_i),
    .ALUCtrl_o(ALUCtrl_o),
    .stall_o  (stall_o),
    .busy_o   (busy_o),
    .hi_o     (hi_o),
    .lo_o     (lo_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] ref_ctrl(input int op, input int f);
    case (op)
      2: case (f)
           32: return 4'b0010;
           34: return 4'b0110;
           36: return 4'b0000;
           37: return 4'b0001;
           42: return 4'b0111;
           0:  return 4'b0011;
           6:  return 4'b0100;
           16: return 4'b1100;
           18: return 4'b1101;
           default: return 4'b1111;
         endcase
      4: return 4'b0010;
      1: return 4'b0110;
      5: return 4'b0111;
      3: return 4'b1001;
      0: return 4'b1010;
      7: return 4'b1011;
      default: return 4'b1111;
    endcase
  endfunction

  task automatic model_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, sq, sr;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (f)
      6'd24: begin p = 64'(sa * sb); m_hi = p[63:32]; m_lo = p[31:0]; end
      6'd25: begin p = 64'(a) * 64'(b); m_hi = p[63:32]; m_lo = p[31:0]; end
      6'd26, 6'd27: begin
        if (b == 32'd0) begin
          m_hi = a;
          m_lo = '1;
        end else if (f == 6'd26) begin
          sq = sa / sb;
          sr = sa % sb;
          p  = 64'(sq);
          m_lo = p[31:0];
          p  = 64'(sr);
          m_hi = p[31:0];
        end else begin
          m_lo = a / b;
          m_hi = a % b;
        end
      end
      default: ;
    endcase
  endtask

  task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                        input bit scramble, input bit then_mflo);
    int          cyc;
    bit          held_ok;
    logic [31:0] h0, l0;
    @(negedge clk_i);
    h0 = m_hi;
    l0 = m_lo;
    valid_i = 1'b1; ALUOp_i = 3'd2; funct_i = f; src1_i = a; src2_i = b;
    #1;
    if (f == 6'd17 || f == 6'd19) begin
      check_eq("mtx_stall", stall_o, 0);
      check_eq("mtx_pre_hi", hi_o, h0);
      @(negedge clk_i);
      if (f == 6'd17) m_hi = a;
      else            m_lo = a;
      valid_i = 1'b0;
      #1;
      check_eq("mtx_hi", hi_o, m_hi);
      check_eq("mtx_lo", lo_o, m_lo);
      return;
    end
    model_op(f, a, b);
    cyc     = 0;
    held_ok = 1'b1;
    while (stall_o === 1'b1 && cyc < 200) begin
      cyc++;
      @(negedge clk_i);
      if (scramble) begin
        src1_i  = $urandom;
        src2_i  = $urandom;
        funct_i = ($urandom_range(0, 1) == 1) ? 6'd17 : 6'd19;
      end
      #1;
      if (hi_o !== h0 || lo_o !== l0) held_ok = 1'b0;
    end
    check_eq("stall_len", 64'(cyc), 64'(W + 1));
    check_eq("fix_busy", busy_o, 1);
    check_eq("hilo_hold", held_ok, 1);
    if (then_mflo) begin
      valid_i = 1'b1; ALUOp_i = 3'd2; funct_i = 6'd18;
    end else begin
      valid_i = 1'b0;
    end
    @(negedge clk_i);
    #1;
    check_eq("done_busy", busy_o, 0);
    check_eq("done_hi", hi_o, m_hi);
    check_eq("done_lo", lo_o, m_lo);
    if (then_mflo) begin
      check_eq("mflo_ctrl", ALUCtrl_o, 4'b1101);
      @(negedge clk_i);
      #1;
      check_eq("no_restart_busy", busy_o, 0);
      check_eq("no_restart_stall", stall_o, 0);
      valid_i = 1'b0;
    end
  endtask

  initial begin
    int          functs [11] = '{0, 6, 16, 18, 24, 32, 34, 36, 37, 42, 63};
    logic [5:0]  md_ops [6]  = '{6'd17, 6'd19, 6'd24, 6'd25, 6'd26, 6'd27};
    logic [31:0] ra, rb;
    logic [5:0]  rf;

    #12;
    check_eq("rst_hi", hi_o, 0);
    check_eq("rst_lo", lo_o, 0);
    check_eq("rst_busy", busy_o, 0);
    check_eq("rst_stall", stall_o, 0);
    @(negedge clk_i);
    rst_i = 1'b1;

    valid_i = 1'b0;
    for (int op = 0; op < 8; op++) begin
      foreach (functs[k]) begin
        ALUOp_i = 3'(op);
        funct_i = 6'(functs[k]);
        #1;
        check_eq($sformatf("dec_op%0d_f%0d", op, functs[k]), ALUCtrl_o, ref_ctrl(op, functs[k]));
        check_eq("dec_x", $isunknown(ALUCtrl_o), 0);
      end
    end

    run_op(6'd24, 32'd7, 32'hFFFF_FFFD, 1'b0, 1'b0);
    check_eq("mult_hi", hi_o, 32'hFFFF_FFFF);
    check_eq("mult_lo", lo_o, 32'hFFFF_FFEB);
    run_op(6'd27, 32'd100, 32'd7, 1'b0, 1'b0);
    check_eq("divu_lo", lo_o, 32'd14);
    check_eq("divu_hi", hi_o, 32'd2);
    run_op(6'd26, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
    check_eq("div_neg_lo", lo_o, 32'hFFFF_FFFD);
    check_eq("div_neg_hi", hi_o, 32'hFFFF_FFFF);
    run_op(6'd26, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    check_eq("div_ovf_lo", lo_o, 32'h8000_0000);
    check_eq("div_ovf_hi", hi_o, 32'd0);
    run_op(6'd27, 32'h1234_5678, 32'd0, 1'b1, 1'b0);
    check_eq("div0_hi", hi_o, 32'h1234_5678);
    check_eq("div0_lo", lo_o, 32'hFFFF_FFFF);
    run_op(6'd17, 32'hDEAD_BEEF, 32'd0, 1'b0, 1'b0);
    check_eq("mthi_val", hi_o, 32'hDEAD_BEEF);
    @(negedge clk_i);
    valid_i = 1'b1; ALUOp_i = 3'd2; funct_i = 6'd18;
    #1;
    check_eq("mflo_dec", ALUCtrl_o, 4'b1101);
    valid_i = 1'b0;

    // Abort a multiply with reset partway through.
    @(negedge clk_i);
    valid_i = 1'b1; ALUOp_i = 3'd2; funct_i = 6'd24; src1_i = 32'd7; src2_i = 32'hFFFF_FFFD;
    repeat (10) @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    m_hi = '0;
    m_lo = '0;
    check_eq("abort_busy", busy_o, 0);
    check_eq("abort_stall", stall_o, 0);
    check_eq("abort_hi", hi_o, 0);
    check_eq("abort_lo", lo_o, 0);
    @(negedge clk_i);
    valid_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b1;
    run_op(6'd25, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0);
    check_eq("multu_hi", hi_o, 32'd1);
    check_eq("multu_lo", lo_o, 32'hFFFF_FFFE);

    run_op(6'd24, 32'h0000_1234, 32'h8765_4321, 1'b0, 1'b1);

    for (int i = 0; i < 30; i++) begin
      rf = md_ops[$urandom_range(0, 5)];
      ra = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : 32'($urandom);
      case ($urandom_range(0, 3))
        0:       rb = 32'd0;
        1:       rb = 32'hFFFF_FFFF;
        2:       rb = 32'($urandom_range(1, 20));
        default: rb = 32'($urandom);
      endcase
      run_op(rf, ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
